sig_dump_ctrl: RTL

//  Responder for the CPU's halt/signature MMIO stores. Snoops the data store bus and latches
//  the signature begin/end byte addresses. On a halt store it walks memory over the data read

---
 rtl/sig_dump_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sig_dump_ctrl.sv
// Halt/signature MMIO responder: latches the signature bounds, then streams the signature words out.
// Define SIG_DUMP_CHECKSUM_EN to append a wrapping sum of all dumped words as one final word.
module sig_dump_ctrl #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] ADDR_HALT      = XLEN'(32'h2000_0000),
    parameter logic [XLEN-1:0] ADDR_SIG_BEGIN = ADDR_HALT + XLEN'(XLEN / 8),
    parameter logic [XLEN-1:0] ADDR_SIG_END   = ADDR_HALT + XLEN'(2 * XLEN / 8)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic            mem_rd,
    output logic [XLEN-2:0] mem_addr,
    input  logic [XLEN-1:0] load_data,
    output logic            dout_valid,
    output logic [XLEN-1:0] dout_data,
    input  logic            dout_ready,
    output logic            busy,
    output logic            done
);

    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(XLEN / 8);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(WORD_BYTES - XLEN'(1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
`ifdef SIG_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] sig_begin_q, sig_begin_d;
    logic [XLEN-1:0] sig_end_q, sig_end_d;
    logic [XLEN-1:0] ptr_q, ptr_d;
    logic [XLEN-1:0] dout_data_q, dout_data_d;
    logic [XLEN-2:0] mem_addr_q, mem_addr_d;
    logic            mem_rd_q, mem_rd_d;
    logic            dout_valid_q, dout_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef SIG_DUMP_CHECKSUM_EN
    logic [XLEN-1:0] csum_q, csum_d;
`endif

    always_comb begin
        state_d     = state_q;
        sig_begin_d = sig_begin_q;
        sig_end_d   = sig_end_q;
        ptr_d       = ptr_q;
        dout_data_d = dout_data_q;
`ifdef SIG_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (store) begin
                    if (address == ADDR_SIG_BEGIN) begin
                        sig_begin_d = store_data & ALIGN_MASK;
                    end else if (address == ADDR_SIG_END) begin
                        sig_end_d = store_data & ALIGN_MASK;
                    end else if (address == ADDR_HALT && store_data[31:0] == 32'd1) begin
                        ptr_d = sig_begin_q;
                        if (sig_end_q <= sig_begin_q) begin
`ifdef SIG_DUMP_CHECKSUM_EN
                            state_d     = S_CSUM;
                            dout_data_d = csum_q;
`else
                            state_d     = S_DONE;
`endif
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                // dout_data_q doubles as the hold register for the fetched word
                dout_data_d = load_data;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (dout_ready) begin
                    ptr_d = ptr_q + WORD_BYTES;
`ifdef SIG_DUMP_CHECKSUM_EN
                    csum_d = csum_q + dout_data_q;
`endif
                    if (ptr_d >= sig_end_q) begin
`ifdef SIG_DUMP_CHECKSUM_EN
                        state_d     = S_CSUM;
                        dout_data_d = csum_d;
`else
                        state_d     = S_DONE;
`endif
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
`ifdef SIG_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (dout_ready) state_d = S_DONE;
            end
`endif
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so derive them from the state being entered
        mem_rd_d     = (state_d == S_READ);
        mem_addr_d   = (state_d == S_READ) ? ptr_d[XLEN-1:1] : '0;
`ifdef SIG_DUMP_CHECKSUM_EN
        dout_valid_d = (state_d == S_SEND) || (state_d == S_CSUM);
`else
        dout_valid_d = (state_d == S_SEND);
`endif
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sig_begin_q  <= '0;
            sig_end_q    <= '0;
            ptr_q        <= '0;
            dout_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SIG_DUMP_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sig_begin_q  <= sig_begin_d;
            sig_end_q    <= sig_end_d;
            ptr_q        <= ptr_d;
            dout_data_q  <= dout_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SIG_DUMP_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
